spike_stream_tx: RTL and testbench

SPIKE_STREAM_TX -- requirements
Module: spike_stream_tx

---
 rtl/spike_stream_tx.sv | 126 ++++++++++++
 tb/tb_spike_stream_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_stream_tx.sv
// rtl/spike_stream_tx.sv - spike bitmap to AXI-Stream event beat serializer
module spike_stream_tx #(
  parameter int NUM_NEURONS = 64,
  parameter int DATA_WIDTH  = 48,
  parameter int TS_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] frame_bitmap,
  input  logic [TS_WIDTH-1:0]    frame_timestep,
  input  logic [7:0]             frame_layer_id,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic [31:0]            spikes_sent,
  output logic [31:0]            frames_sent
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [NUM_NEURONS-1:0] BITMAP_ONE = {{(NUM_NEURONS-1){1'b0}}, 1'b1};

  // Neuron id carried by the empty-frame marker beat
  localparam logic [15:0] MARKER_ID = 16'hFFFF;

  logic [0:0]             state;
  logic [NUM_NEURONS-1:0] pend_bitmap;
  logic [TS_WIDTH-1:0]    pend_ts;
  logic [7:0]             pend_layer;

  logic [15:0]            low_id;
  logic                   pend_empty;
  logic                   pend_single;
  logic                   in_send;
  logic                   accept;
  logic                   beat_fire;
  logic                   last_fire;
  logic [7:0]             beat_value;
  logic [47:0]            beat_word;

  // Lowest set bit of the pending bitmap; falls back to the marker id when empty
  always_comb begin
    low_id = MARKER_ID;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pend_bitmap[i]) begin
        low_id = 16'(i);
      end
    end
  end

  assign in_send    = (state == SEND);
  assign pend_empty = (pend_bitmap == '0);
  // Exactly one bit set: clearing the lowest set bit leaves nothing behind
  assign pend_single = !pend_empty && ((pend_bitmap & (pend_bitmap - BITMAP_ONE)) == '0);

  // The ready path is gated by reset_n so it reads low while reset is held
  assign frame_ready = reset_n && enable && (state == IDLE);
  assign accept      = frame_valid && frame_ready;

  // Outputs derive from state and pending registers only, so they hold
  // steady under backpressure and fall the moment reset clears the state
  assign m_axis_tvalid = in_send;
  assign m_axis_tlast  = in_send && (pend_empty || pend_single);
  assign beat_value    = pend_empty ? 8'h00 : 8'h01;
  assign beat_word     = {16'(pend_ts), pend_layer, low_id, beat_value};
  assign m_axis_tdata  = in_send ? DATA_WIDTH'(beat_word) : '0;
  assign busy          = in_send;

  assign beat_fire = in_send && m_axis_tready;
  assign last_fire = beat_fire && m_axis_tlast;

  // Frame capture and per-beat retirement of the reported neuron
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pend_bitmap <= '0;
      pend_ts     <= '0;
      pend_layer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pend_bitmap <= frame_bitmap;
            pend_ts     <= frame_timestep;
            pend_layer  <= frame_layer_id;
            state       <= SEND;
          end
        end
        SEND: begin
          if (beat_fire) begin
            // Clears the lowest set bit; an empty (marker) bitmap stays empty
            pend_bitmap <= pend_bitmap & (pend_bitmap - BITMAP_ONE);
            if (last_fire) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Transfer statistics; marker beats count toward frames only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spikes_sent <= '0;
      frames_sent <= '0;
    end else begin
      if (beat_fire && !pend_empty) begin
        spikes_sent <= spikes_sent + 32'd1;
      end
      if (last_fire) begin
        frames_sent <= frames_sent + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_spike_stream_tx.sv
// tb/tb_spike_stream_tx.sv - directed self-checking bench for spike_stream_tx
module tb_spike_stream_tx;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [63:0] frame_bitmap;
  logic [15:0] frame_timestep;
  logic [7:0]  frame_layer_id;
  logic        frame_valid;
  logic        frame_ready;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] spikes_sent;
  logic [31:0] frames_sent;

  int n_total;
  int n_bad;

  spike_stream_tx #(
    .NUM_NEURONS(64),
    .DATA_WIDTH (48),
    .TS_WIDTH   (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .frame_bitmap  (frame_bitmap),
    .frame_timestep(frame_timestep),
    .frame_layer_id(frame_layer_id),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .spikes_sent   (spikes_sent),
    .frames_sent   (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [47:0] data, input logic last);
    check_val({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd1);
    check_val({tag, "_tdata"},  64'(m_axis_tdata),  64'(data));
    check_val({tag, "_tlast"},  64'(m_axis_tlast),  64'(last));
  endtask

  task automatic idle_chk(input string tag, input logic exp_ready);
    check_val({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check_val({tag, "_busy"},   64'(busy),          64'd0);
    check_val({tag, "_ready"},  64'(frame_ready),   64'(exp_ready));
  endtask

  task automatic offer(input logic [63:0] bm, input logic [15:0] ts, input logic [7:0] layer);
    frame_bitmap   = bm;
    frame_timestep = ts;
    frame_layer_id = layer;
    frame_valid    = 1'b1;
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    reset_n        = 1'b0;
    enable         = 1'b1;
    frame_bitmap   = '0;
    frame_timestep = '0;
    frame_layer_id = '0;
    frame_valid    = 1'b0;
    m_axis_tready  = 1'b1;

    // Reset state, with enable already high
    repeat (2) @(negedge clk);
    check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("rst_tlast",  64'(m_axis_tlast),  64'd0);
    check_val("rst_tdata",  64'(m_axis_tdata),  64'd0);
    check_val("rst_ready",  64'(frame_ready),   64'd0);
    check_val("rst_busy",   64'(busy),          64'd0);
    check_val("rst_spikes", 64'(spikes_sent),   64'd0);
    check_val("rst_frames", 64'(frames_sent),   64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", 64'(frame_ready), 64'd1);

    // Frame 0x25, ts 7, layer 2: neurons 0, 2, 5 back to back
    offer(64'h25, 16'd7, 8'd2);
    @(negedge clk);
    frame_valid = 1'b0;
    check_val("a_busy",  64'(busy),        64'd1);
    check_val("a_ready", 64'(frame_ready), 64'd0);
    beat("a_n0", 48'h0007_02_0000_01, 1'b0);
    @(negedge clk);
    beat("a_n2", 48'h0007_02_0002_01, 1'b0);
    @(negedge clk);
    beat("a_n5", 48'h0007_02_0005_01, 1'b1);
    @(negedge clk);
    idle_chk("a_end", 1'b1);
    check_val("a_spikes", 64'(spikes_sent), 64'd3);
    check_val("a_frames", 64'(frames_sent), 64'd1);

    // Empty frame produces one marker beat
    offer(64'h0, 16'd3, 8'd0);
    @(negedge clk);
    frame_valid = 1'b0;
    beat("b_marker", 48'h0003_00_FFFF_00, 1'b1);
    @(negedge clk);
    idle_chk("b_end", 1'b1);
    check_val("b_spikes", 64'(spikes_sent), 64'd3);
    check_val("b_frames", 64'(frames_sent), 64'd2);

    // Bits 1 and 63 with tready low for 10 cycles
    m_axis_tready = 1'b0;
    offer(64'h8000_0000_0000_0002, 16'd9, 8'd1);
    @(negedge clk);
    frame_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat($sformatf("c_hold%0d", i), 48'h0009_01_0001_01, 1'b0);
      if (i < 9) @(negedge clk);
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    beat("c_n63", 48'h0009_01_003F_01, 1'b1);
    @(negedge clk);
    idle_chk("c_end", 1'b1);
    check_val("c_spikes", 64'(spikes_sent), 64'd5);
    check_val("c_frames", 64'(frames_sent), 64'd3);

    // Back-to-back frames with frame_valid held; inputs change mid-frame
    offer(64'h3, 16'd10, 8'd4);
    @(negedge clk);
    offer(64'h8, 16'd11, 8'd5);
    check_val("d_ready_send0", 64'(frame_ready), 64'd0);
    beat("d_f1n0", 48'h000A_04_0000_01, 1'b0);
    @(negedge clk);
    check_val("d_ready_send1", 64'(frame_ready), 64'd0);
    beat("d_f1n1", 48'h000A_04_0001_01, 1'b1);
    @(negedge clk);
    idle_chk("d_gap", 1'b1);
    @(negedge clk);
    frame_valid = 1'b0;
    check_val("d_ready_send2", 64'(frame_ready), 64'd0);
    beat("d_f2n3", 48'h000B_05_0003_01, 1'b1);
    @(negedge clk);
    idle_chk("d_end", 1'b1);
    check_val("d_spikes", 64'(spikes_sent), 64'd8);
    check_val("d_frames", 64'(frames_sent), 64'd5);

    // enable dropped during a 4-bit frame: frame completes, no new accept
    offer(64'hF0, 16'd1, 8'd1);
    @(negedge clk);
    enable = 1'b0;
    beat("e_n4", 48'h0001_01_0004_01, 1'b0);
    @(negedge clk);
    beat("e_n5", 48'h0001_01_0005_01, 1'b0);
    check_val("e_ready5", 64'(frame_ready), 64'd0);
    @(negedge clk);
    beat("e_n6", 48'h0001_01_0006_01, 1'b0);
    @(negedge clk);
    beat("e_n7", 48'h0001_01_0007_01, 1'b1);
    @(negedge clk);
    idle_chk("e_idle0", 1'b0);
    @(negedge clk);
    idle_chk("e_idle1", 1'b0);
    check_val("e_spikes", 64'(spikes_sent), 64'd12);
    check_val("e_frames", 64'(frames_sent), 64'd6);
    frame_valid = 1'b0;
    enable      = 1'b1;
    @(negedge clk);
    check_val("e_ready_back", 64'(frame_ready), 64'd1);

    // Reset pulse after 2 of 4 beats
    offer(64'h0F, 16'd2, 8'd3);
    @(negedge clk);
    frame_valid = 1'b0;
    beat("f_n0", 48'h0002_03_0000_01, 1'b0);
    @(negedge clk);
    beat("f_n1", 48'h0002_03_0001_01, 1'b0);
    @(negedge clk);
    beat("f_n2", 48'h0002_03_0002_01, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("f_async_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_val("f_async_busy",   64'(busy),          64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    idle_chk("f_after", 1'b1);
    check_val("f_spikes", 64'(spikes_sent), 64'd0);
    check_val("f_frames", 64'(frames_sent), 64'd0);
    repeat (3) @(negedge clk);
    idle_chk("f_no_residual", 1'b1);
    check_val("f_tdata_zero", 64'(m_axis_tdata), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
